// File: rtl/ramsdp_fifo_ctrl_pkg.sv
// rtl/ramsdp_fifo_ctrl_pkg.sv - shared constants and depth helper for the ramsdp FIFO controller
//
// Purpose: default geometry for the FIFO and a helper that turns an address
//          width into an entry count.
// Contents: DEFAULT_DW, DEFAULT_AW, fifo_depth().
package ramsdp_fifo_ctrl_pkg;

    localparam int DEFAULT_DW = 32;
    localparam int DEFAULT_AW = 6;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/ramsdp_fifo_ctrl_if.sv
// rtl/ramsdp_fifo_ctrl_if.sv - push/pop handshake bundle for the ramsdp FIFO controller
//
// Purpose: groups the producer side, consumer side and status of the FIFO.
// Signals: clear, in_valid/in_ready/in_data (push side),
//          out_valid/out_ready/out_data (pop side), count/full/empty (status).
// Modports: master - the producer/consumer driving the FIFO,
//           slave  - the FIFO controller itself.
interface ramsdp_fifo_ctrl_if
    import ramsdp_fifo_ctrl_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int AW = DEFAULT_AW
);

    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, full, empty
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, full, empty
    );

endinterface

// File: rtl/ramsdp_fifo_ctrl_ramsdp.sv
// rtl/ramsdp_fifo_ctrl_ramsdp.sv - simple dual-port RAM with registered outputs on both ports
//
// Purpose: FIFO storage. Port A writes (and returns the old word on dout_a),
//          port B is read-only with a registered dout_b. No reset on contents
//          or output registers.
// Ports: clk; we_a, addr_a, din_a, dout_a (port A); addr_b, dout_b (port B).
module ramsdp #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] din_a,
    output logic [DW-1:0] dout_a,
    input  logic [AW-1:0] addr_b,
    output logic [DW-1:0] dout_b
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
        dout_a <= mem[addr_a];
    end

    always_ff @(posedge clk) begin
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/ramsdp_fifo_ctrl.sv
// rtl/ramsdp_fifo_ctrl.sv - first-word-fall-through FIFO controller over one ramsdp instance
//
// Purpose: sequences a ramsdp as FIFO storage with valid/ready on both sides,
//          one push and one pop per cycle sustained, 2-cycle push-to-head latency.
// Ports: clk, rst (async, active-high);
//        bus (slave modport): clear, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, count, full, empty.
module ramsdp_fifo_ctrl
    import ramsdp_fifo_ctrl_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int AW = DEFAULT_AW
) (
    input  logic                clk,
    input  logic                rst,
    ramsdp_fifo_ctrl_if.slave   bus
);

    localparam int          DEPTH   = fifo_depth(AW);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   avail;      // written to RAM but not yet fetched to dout_b
    logic          out_valid;

    logic          in_ready;
    logic          push;
    logic          pop;
    logic          fetch;
    logic [AW-1:0] addr_b;

    // in_ready comes from the registered count, so a pop cannot make room for
    // a push in the same cycle.
    assign in_ready = (count != DEPTH_C);
    assign push     = bus.in_valid & in_ready & ~bus.clear;
    assign pop      = out_valid & bus.out_ready;
    assign fetch    = (avail != '0) & (~out_valid | bus.out_ready);

    // Without a fetch, keep re-reading the presented head so dout_b stays put.
    // The head slot is not freed until pop, so port A can never hit it.
    assign addr_b   = fetch ? rd_ptr : rd_ptr - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            avail     <= '0;
            out_valid <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            avail     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // avail rises the edge after the write, so a word is only fetched
            // once it is already in the array (no read-during-write on port B).
            avail     <= avail + (AW+1)'(push) - (AW+1)'(fetch);
            count     <= count + (AW+1)'(push) - (AW+1)'(pop);
            out_valid <= fetch ? 1'b1 : (pop ? 1'b0 : out_valid);
        end
    end

    ramsdp #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk    (clk),
        .we_a   (push),
        .addr_a (wr_ptr),
        .din_a  (bus.in_data),
        .dout_a (),
        .addr_b (addr_b),
        .dout_b (bus.out_data)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.count     = count;
    assign bus.full      = (count == DEPTH_C);
    assign bus.empty     = (count == '0);

    a_count_le_depth: assert property (@(posedge clk) disable iff (rst)
        count <= DEPTH_C);
    a_avail_le_count: assert property (@(posedge clk) disable iff (rst)
        avail <= count);
    a_occupancy: assert property (@(posedge clk) disable iff (rst)
        (avail + (AW+1)'(out_valid)) <= count);

endmodule

// File: tb/tb_ramsdp_fifo_ctrl.sv
// tb/tb_ramsdp_fifo_ctrl.sv - self-checking bench for ramsdp_fifo_ctrl (AW=2, DW=32)
module tb_ramsdp_fifo_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    typedef struct {
        logic          in_valid;
        logic [DW-1:0] in_data;
        logic          out_ready;
        logic          clear;
        logic          exp_ov;
        logic [DW-1:0] exp_data;
        logic [AW:0]   exp_count;
        string         tag;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];

    ramsdp_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus_if ();

    ramsdp_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic exp_ov, input logic [DW-1:0] exp_data,
                                input logic [AW:0] exp_count);
        check({tag, ".count"},     DW'(bus_if.count),     DW'(exp_count));
        check({tag, ".out_valid"}, DW'(bus_if.out_valid), DW'(exp_ov));
        check({tag, ".full"},      DW'(bus_if.full),      DW'(exp_count == DEPTH));
        check({tag, ".empty"},     DW'(bus_if.empty),     DW'(exp_count == 0));
        check({tag, ".in_ready"},  DW'(bus_if.in_ready),  DW'(exp_count != DEPTH));
        if (exp_ov) begin
            check({tag, ".out_data"}, bus_if.out_data, exp_data);
        end
    endtask

    task automatic add_vec(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic clr,
                           input logic ov, input logic [DW-1:0] od, input int cnt, input string tag);
        vec_t v;
        v.in_valid  = iv;
        v.in_data   = id;
        v.out_ready = ordy;
        v.clear     = clr;
        v.exp_ov    = ov;
        v.exp_data  = od;
        v.exp_count = (AW+1)'(cnt);
        v.tag       = tag;
        vecs.push_back(v);
    endtask

    // Inputs are applied just after an edge, held across the next edge and
    // the state after that edge is compared.
    task automatic apply(input vec_t v);
        bus_if.in_valid  = v.in_valid;
        bus_if.in_data   = v.in_data;
        bus_if.out_ready = v.out_ready;
        bus_if.clear     = v.clear;
        @(posedge clk);
        #1;
        check_status(v.tag, v.exp_ov, v.exp_data, v.exp_count);
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic clr,
                        input logic ov, input logic [DW-1:0] od, input int cnt, input string tag);
        vec_t v;
        v.in_valid  = iv;
        v.in_data   = id;
        v.out_ready = ordy;
        v.clear     = clr;
        v.exp_ov    = ov;
        v.exp_data  = od;
        v.exp_count = (AW+1)'(cnt);
        v.tag       = tag;
        apply(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fill three, overfill to full, drop a fifth push, then drain in order.
        add_vec(1, 32'h11, 0, 0, 0, 32'h00, 1, "fill0");
        add_vec(1, 32'h22, 0, 0, 1, 32'h11, 2, "fill1");
        add_vec(1, 32'h33, 0, 0, 1, 32'h11, 3, "fill2");
        add_vec(1, 32'h44, 0, 0, 1, 32'h11, 4, "fill3");
        add_vec(1, 32'hFF, 0, 0, 1, 32'h11, 4, "push_at_full");
        add_vec(0, 32'h00, 0, 0, 1, 32'h11, 4, "hold_full");
        add_vec(0, 32'h00, 1, 0, 1, 32'h22, 3, "drain0");
        add_vec(0, 32'h00, 1, 0, 1, 32'h33, 2, "drain1");
        add_vec(0, 32'h00, 1, 0, 1, 32'h44, 1, "drain2");
        add_vec(0, 32'h00, 1, 0, 0, 32'h00, 0, "drain3");
        add_vec(0, 32'h00, 1, 0, 0, 32'h00, 0, "pop_empty");
        // Streaming: push k and pop every cycle; head lags the push by one row.
        for (int j = 0; j < 20; j++) begin
            add_vec(1, 32'h100 + j, 1, 0, (j >= 1), (j >= 1) ? 32'h100 + j - 1 : 32'h0,
                    (j == 0) ? 1 : 2, $sformatf("stream%0d", j));
        end
        add_vec(0, 32'h00, 1, 0, 1, 32'h113, 1, "stream_tail0");
        add_vec(0, 32'h00, 1, 0, 0, 32'h000, 0, "stream_tail1");
        // Single word sought immediately: valid only two edges after the push.
        add_vec(1, 32'h5A, 1, 0, 0, 32'h00, 1, "single0");
        add_vec(0, 32'h00, 1, 0, 1, 32'h5A, 1, "single1");
        add_vec(0, 32'h00, 1, 0, 0, 32'h00, 0, "single2");

        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        bus_if.clear     = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 1'b0, '0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i]);
        end

        // clear with three entries and a presented head, overriding push and pop.
        step(1, 32'hC1, 0, 0, 0, 32'h00, 1, "clr_fill0");
        step(1, 32'hC2, 0, 0, 1, 32'hC1, 2, "clr_fill1");
        step(1, 32'hC3, 0, 0, 1, 32'hC1, 3, "clr_fill2");
        step(1, 32'hBB, 1, 1, 0, 32'h00, 0, "clear");
        step(1, 32'hA5, 1, 0, 0, 32'h00, 1, "post_clear0");
        step(0, 32'h00, 1, 0, 1, 32'hA5, 1, "post_clear1");
        step(0, 32'h00, 1, 0, 0, 32'h00, 0, "post_clear2");

        // Asynchronous reset in the middle of a drain, between clock edges.
        step(1, 32'hD1, 0, 0, 0, 32'h00, 1, "rst_fill0");
        step(1, 32'hD2, 0, 0, 1, 32'hD1, 2, "rst_fill1");
        step(1, 32'hD3, 0, 0, 1, 32'hD1, 3, "rst_fill2");
        step(0, 32'h00, 1, 0, 1, 32'hD2, 2, "rst_drain0");
        #3;
        rst = 1'b1;
        #1;
        check_status("async_rst", 1'b0, '0, 0);
        #2;
        rst = 1'b0;
        step(1, 32'h77, 1, 0, 0, 32'h00, 1, "post_rst0");
        step(0, 32'h00, 1, 0, 1, 32'h77, 1, "post_rst1");
        step(0, 32'h00, 1, 0, 0, 32'h00, 0, "post_rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
